// File: rtl/seven_segment_pkg.sv
// Shared seven-segment definitions: glyph table (g..a, active-high lit segments),
// cathode bit positions and the segment-pattern to hex lookup.
package seven_segment_pkg;

   localparam int CATH_DP = 7;

   localparam logic [6:0] SEG_GLYPH [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   typedef struct packed {
      logic       valid;
      logic [3:0] value;
      logic       dp;
   } seg_decode_t;

   // Returns {valid, value}; valid is 0 when the lit pattern is not a hex glyph.
   function automatic logic [4:0] seg_to_hex(input logic [6:0] seg);
      logic [4:0] r_hex;
      r_hex = '0;
      for (int v = 0; v < 16; v++) begin
         if (seg == SEG_GLYPH[v]) r_hex = {1'b1, 4'(v)};
      end
      return r_hex;
   endfunction

endpackage

// File: rtl/cathode_decode.sv
// Combinational decode of an active-low cathode byte into hex value, glyph
// validity and digit point.
module cathode_decode
   import seven_segment_pkg::*;
(
   input  logic [7:0]  i_cathode,
   output seg_decode_t o_decoded
);

   logic [4:0] w_hex;

   always_comb begin
      w_hex           = seg_to_hex(~i_cathode[6:0]);
      o_decoded.valid = w_hex[4];
      o_decoded.value = w_hex[3:0];
      o_decoded.dp    = ~i_cathode[CATH_DP];
   end

endmodule

// File: rtl/seven_segment_decode.sv
// Receive side of a multiplexed seven-segment scan bus: synchronizes the pins,
// waits for each dwell to settle and latches the decoded digit per anode.
module seven_segment_decode
   import seven_segment_pkg::*;
#(
   parameter int NUM_SEGMENTS   = 8,
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [NUM_SEGMENTS-1:0]      anode,
   input  logic [7:0]                   cathode,
   output logic [NUM_SEGMENTS-1:0][3:0] digits,
   output logic [NUM_SEGMENTS-1:0]      digit_point,
   output logic [NUM_SEGMENTS-1:0]      digit_valid,
   output logic                         frame_done,
   output logic                         scan_error,
   output logic                         stalled
);

   localparam int BUS_W   = NUM_SEGMENTS + 8;
   localparam int DWELL_W = $clog2(STABLE_CYCLES);
   localparam int TO_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(STABLE_CYCLES - 1);
   localparam logic [TO_W-1:0]    TO_MAX    = TO_W'(TIMEOUT_CYCLES - 1);

   logic [BUS_W-1:0]        r_meta;
   logic [BUS_W-1:0]        r_sync;
   logic [BUS_W-1:0]        r_prev;
   logic [DWELL_W-1:0]      r_dwell;
   logic                    r_captured;
   logic [NUM_SEGMENTS-1:0] r_seen;
   logic [TO_W-1:0]         r_timeout;

   logic                    w_changed;
   logic                    w_cap;
   logic [NUM_SEGMENTS-1:0] w_low;
   logic                    w_one_low;
   logic                    w_multi_low;
   logic                    w_digit_cap;
   logic                    w_err_cap;
   logic [NUM_SEGMENTS-1:0] w_seen_next;
   seg_decode_t             w_dec;

   // Preset to all-ones so the idle (inactive) bus is what the flops hold.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_meta <= '1;
         r_sync <= '1;
         r_prev <= '1;
      end else begin
         r_meta <= {anode, cathode};
         r_sync <= r_meta;
         r_prev <= r_sync;
      end
   end

   always_comb begin
      w_changed   = (r_sync != r_prev);
      w_cap       = (r_dwell == DWELL_MAX) && !r_captured;
      w_low       = ~r_prev[BUS_W-1:8];
      w_one_low   = $onehot(w_low);
      w_multi_low = (w_low != '0) && !w_one_low;
      w_digit_cap = w_cap && w_one_low;
      w_err_cap   = w_cap && w_multi_low;
      w_seen_next = r_seen | w_low;
   end

   // Capture reads r_prev, the settled pattern, so a change arriving in the
   // capture cycle itself still lets the finished dwell be recorded.
   cathode_decode u_cathode_decode (
      .i_cathode (r_prev[7:0]),
      .o_decoded (w_dec)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_dwell    <= '0;
         r_captured <= 1'b0;
      end else if (w_changed) begin
         r_dwell    <= '0;
         r_captured <= 1'b0;
      end else begin
         if (r_dwell != DWELL_MAX) r_dwell <= r_dwell + 1'b1;
         if (w_cap) r_captured <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digits      <= '0;
         digit_point <= '0;
         digit_valid <= '0;
         frame_done  <= 1'b0;
         scan_error  <= 1'b0;
         r_seen      <= '0;
      end else begin
         scan_error <= w_err_cap;
         frame_done <= 1'b0;
         if (w_digit_cap) begin
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
               if (w_low[i]) begin
                  digit_point[i] <= w_dec.dp;
                  digit_valid[i] <= w_dec.valid;
                  if (w_dec.valid) digits[i] <= w_dec.value;
               end
            end
            if (&w_seen_next) begin
               frame_done <= 1'b1;
               r_seen     <= '0;
            end else begin
               r_seen <= w_seen_next;
            end
         end
      end
   end

   // Only a real digit capture counts as bus activity for the stall watchdog.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timeout <= '0;
         stalled   <= 1'b0;
      end else if (w_digit_cap) begin
         r_timeout <= '0;
         stalled   <= 1'b0;
      end else if (r_timeout == TO_MAX) begin
         stalled <= 1'b1;
      end else begin
         r_timeout <= r_timeout + 1'b1;
      end
   end

endmodule

// File: tb/tb_seven_segment_decode.sv
// Self-checking bench for seven_segment_decode: vector table, directed corner
// sequences and randomized dwells against a dwell-level reference model.
module tb_seven_segment_decode;

   localparam int S = 16;
   localparam int T = 64;
   localparam logic [6:0] GLY [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   logic             clk;
   logic             reset_n;
   logic [7:0]       anode;
   logic [7:0]       cathode;
   logic [7:0][3:0]  digits;
   logic [7:0]       digit_point;
   logic [7:0]       digit_valid;
   logic             frame_done;
   logic             scan_error;
   logic             stalled;

   int checks   = 0;
   int failures = 0;
   int n_frames = 0;
   int n_errs   = 0;

   logic [7:0][3:0] m_dig;
   logic [7:0]      m_dp;
   logic [7:0]      m_val;
   logic [7:0]      m_seen;
   int              m_frames = 0;
   int              m_errs   = 0;

   typedef struct {
      logic [7:0] an;
      logic [7:0] ca;
      int         idx;
      logic [3:0] e_dig;
      logic       e_dp;
      logic       e_val;
   } vec_t;
   vec_t vecs[$];

   seven_segment_decode #(
      .NUM_SEGMENTS   (8),
      .STABLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .anode       (anode),
      .cathode     (cathode),
      .digits      (digits),
      .digit_point (digit_point),
      .digit_valid (digit_valid),
      .frame_done  (frame_done),
      .scan_error  (scan_error),
      .stalled     (stalled)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_done === 1'b1) n_frames++;
      if (scan_error === 1'b1) n_errs++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Reference: linear search of the hex glyph list; returns {found, value}.
   function automatic logic [4:0] ref_decode(input logic [6:0] lit);
      for (int v = 0; v < 16; v++) if (GLY[v] == lit) return {1'b1, 4'(v)};
      return 5'd0;
   endfunction

   // Model of one completed dwell of at least S synced cycles.
   task automatic model_dwell(input logic [7:0] an, input logic [7:0] ca);
      int lows, idx;
      logic [4:0] d;
      lows = 0; idx = 0;
      for (int i = 0; i < 8; i++) if (!an[i]) begin lows++; idx = i; end
      if (lows >= 2) m_errs++;
      if (lows == 1) begin
         d = ref_decode(~ca[6:0]);
         m_dp[idx]  = ~ca[7];
         m_val[idx] = d[4];
         if (d[4]) m_dig[idx] = d[3:0];
         m_seen[idx] = 1'b1;
         if (m_seen == 8'hFF) begin
            m_frames++;
            m_seen = 8'h00;
         end
      end
   endtask

   task automatic apply_dwell(input logic [7:0] an, input logic [7:0] ca, input int len);
      @(negedge clk);
      anode   = an;
      cathode = ca;
      repeat (len) @(posedge clk);
      if (len >= S) model_dwell(an, ca);
   endtask

   task automatic check_state(input string tag);
      @(negedge clk);
      chk({tag, ".digits"}, 64'(digits), 64'(m_dig));
      chk({tag, ".dp"}, 64'(digit_point), 64'(m_dp));
      chk({tag, ".valid"}, 64'(digit_valid), 64'(m_val));
      chk({tag, ".frames"}, 64'(n_frames), 64'(m_frames));
      chk({tag, ".errors"}, 64'(n_errs), 64'(m_errs));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("rst.digits", 64'(digits), 64'd0);
      chk("rst.dp", 64'(digit_point), 64'd0);
      chk("rst.valid", 64'(digit_valid), 64'd0);
      chk("rst.flags", 64'({frame_done, scan_error, stalled}), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      m_dig = '0; m_dp = '0; m_val = '0; m_seen = '0;
   endtask

   initial begin
      logic [7:0] cur_an, cur_ca, an, ca;
      int len, k, j, r;
      reset_n = 1'b1;
      anode   = 8'hFF;
      cathode = 8'hFF;
      m_dig = '0; m_dp = '0; m_val = '0; m_seen = '0;
      do_reset();
      repeat (3) @(posedge clk);

      for (int i = 0; i < 8; i++)
         vecs.push_back('{~(8'd1 << i), {1'b1, ~GLY[i]}, i, 4'(i), 1'b0, 1'b1});
      vecs.push_back('{8'hF7, 8'h00, 3, 4'h8, 1'b1, 1'b1});
      vecs.push_back('{8'hF7, {1'b1, ~7'h2A}, 3, 4'h8, 1'b0, 1'b0});

      foreach (vecs[v]) begin
         apply_dwell(vecs[v].an, vecs[v].ca, 20);
         check_state($sformatf("vec%0d", v));
         chk($sformatf("vec%0d.dig", v), 64'(digits[vecs[v].idx]), 64'(vecs[v].e_dig));
         chk($sformatf("vec%0d.dpbit", v), 64'(digit_point[vecs[v].idx]), 64'(vecs[v].e_dp));
         chk($sformatf("vec%0d.vbit", v), 64'(digit_valid[vecs[v].idx]), 64'(vecs[v].e_val));
         if (v == 7) begin
            chk("scan.digits", 64'(digits), 64'h76543210);
            chk("scan.valid", 64'(digit_valid), 64'hFF);
            chk("scan.frame", 64'(n_frames), 64'd1);
         end
      end

      // Dwell one cycle short of settling, then exactly long enough.
      apply_dwell(8'hFE, {1'b1, ~GLY[5]}, S - 1);
      apply_dwell(8'hFF, 8'hFF, 20);
      check_state("short");
      chk("short.dig0", 64'(digits[0]), 64'd0);
      apply_dwell(8'hFE, {1'b1, ~GLY[5]}, S);
      apply_dwell(8'hFF, 8'hFF, 20);
      check_state("exact");
      chk("exact.dig0", 64'(digits[0]), 64'd5);

      k = n_errs;
      apply_dwell(8'hFC, {1'b1, ~GLY[9]}, 20);
      check_state("multi");
      chk("multi.onepulse", 64'(n_errs - k), 64'd1);

      cur_an = 8'hFC;
      cur_ca = {1'b1, ~GLY[9]};
      for (int it = 0; it < 150; it++) begin
         do begin
            r = $urandom_range(0, 9);
            if (r < 7) an = ~(8'd1 << $urandom_range(0, 7));
            else if (r == 7) an = 8'hFF;
            else begin
               an = 8'($urandom);
               k = $urandom_range(0, 7);
               j = (k + $urandom_range(1, 7)) % 8;
               an[k] = 1'b0;
               an[j] = 1'b0;
            end
            if ($urandom_range(0, 4) < 3) ca = {1'($urandom_range(0, 1)), ~GLY[$urandom_range(0, 15)]};
            else ca = 8'($urandom);
         end while ({an, ca} == {cur_an, cur_ca});
         len = ($urandom_range(0, 2) != 0) ? $urandom_range(S + 4, S + 12) : $urandom_range(1, S - 1);
         apply_dwell(an, ca, len);
         if (len >= S) check_state($sformatf("rnd%0d", it));
         cur_an = an;
         cur_ca = ca;
      end

      // Reset mid-frame and mid-dwell; the frame must restart from scratch.
      apply_dwell(8'hFF, 8'hFF, 20);
      do_reset();
      for (int i = 0; i < 4; i++) apply_dwell(~(8'd1 << i), {1'b1, ~GLY[9]}, 20);
      @(negedge clk);
      anode   = 8'hEF;
      cathode = {1'b1, ~GLY[2]};
      repeat (10) @(posedge clk);
      do_reset();
      repeat (9) @(posedge clk);
      apply_dwell(8'hFF, 8'hFF, 20);
      check_state("rstdwell");
      chk("rstdwell.dig4", 64'(digit_valid[4]), 64'd0);
      k = n_frames;
      for (int i = 4; i < 8; i++) apply_dwell(~(8'd1 << i), {1'b0, ~GLY[i + 8]}, 20);
      check_state("rsthalf");
      chk("rsthalf.noframe", 64'(n_frames - k), 64'd0);
      for (int i = 0; i < 4; i++) apply_dwell(~(8'd1 << i), {1'b1, ~GLY[i]}, 20);
      check_state("rstfull");
      chk("rstfull.frame", 64'(n_frames - k), 64'd1);

      // Stall watchdog with the shortened timeout.
      do_reset();
      @(negedge clk);
      anode   = 8'hFF;
      cathode = 8'hFF;
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("stall.early", 64'(stalled), 64'd0);
      repeat (T + 5) @(posedge clk);
      @(negedge clk);
      chk("stall.set", 64'(stalled), 64'd1);
      anode   = 8'hFE;
      cathode = {1'b1, ~GLY[1]};
      repeat (S + 1) @(posedge clk);
      @(negedge clk);
      chk("stall.hold", 64'(stalled), 64'd1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("stall.clear", 64'(stalled), 64'd0);
      chk("stall.dig0", 64'(digits[0]), 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
